adder_share_arb: RTL and testbench

- Arbitrates one shared 32-bit signed adder (module Adder: S = A + B, overflow flag) between NREQ requesters, e.g. the ALU add path, branch-target calculation and address generation.
- Round-robin grant, one operation in flight, registered result returned on a per-requester valid/ready response channel.
- Sits between the issue logic and the datapath adder.

---
 rtl/adder_share_arb.sv | 206 ++++++++++++++++++++
 tb/tb_adder_share_arb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter that shares one 32-bit signed adder
// among NREQ requesters. One operation is in flight at a time. The result is
// registered and returned on a valid/ready response channel.
//
// Optional feature (macro ADDER_SAT_EN): when defined, a result that overflows
// saturates to the most positive or most negative 32-bit value. resp_ovf is
// still set in that case.
//
// FSM states:
//   IDLE | arbitrating; a grant is offered to the next valid requester
//   EXEC | operands latched and driving the adder; result captured on exit
//   RESP | response held until the consumer asserts resp_ready

// Shared datapath adder. S = A + B, with the two's-complement overflow flag.
module adder_share_arb_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_s,
  output logic        o_ovf
);
  assign o_s   = i_a + i_b;
  // Overflow only happens when both operands have the same sign and the
  // sign of the sum differs from it.
  assign o_ovf = (i_a[31] == i_b[31]) && (o_s[31] != i_a[31]);
endmodule

module adder_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  input  logic                 resp_ready,
  output logic [31:0]          resp_sum,
  output logic                 resp_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_resp_valid;
  logic [IDW-1:0]   r_resp_id;
  logic [31:0]      r_resp_sum;
  logic             r_resp_ovf;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic             w_found;
  logic [IDW:0]     w_best_d;
  logic [IDW:0]     w_d;
  logic [IDW:0]     w_i_ext;
  logic [IDW:0]     w_ptr_ext;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic             w_accept;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [31:0]      w_add_s;
  logic             w_add_ovf;
  logic [31:0]      w_result;

  // Round-robin search: pick the valid requester closest to rr_ptr going
  // upward with wrap-around. Distances are computed per requester so the
  // search needs no variable indexing and works for non-power-of-two NREQ.
  always_comb begin
    w_grant   = '0;
    w_gidx    = '0;
    w_found   = 1'b0;
    w_best_d  = (IDW+1)'(NREQ);
    w_d       = '0;
    w_i_ext   = '0;
    w_ptr_ext = {1'b0, r_rr_ptr};
    for (int i = 0; i < NREQ; i++) begin
      w_i_ext = (IDW+1)'(i);
      if (w_i_ext >= w_ptr_ext) begin
        w_d = w_i_ext - w_ptr_ext;
      end else begin
        w_d = w_i_ext + (IDW+1)'(NREQ) - w_ptr_ext;
      end
      if (req_valid[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        w_gidx   = IDW'(i);
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      w_grant[i] = w_found && (w_gidx == IDW'(i));
    end
  end

  // Operand mux for the granted requester (grant is one-hot or zero).
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
      end
    end
  end

  // Grants are only offered in IDLE; rst gates them immediately so nothing
  // is offered while reset is held.
  assign req_ready = ((r_state == IDLE) && !rst) ? w_grant : '0;
  assign w_accept  = |(req_ready & req_valid);
  assign w_ptr_nxt = (w_gidx == IDW'(NREQ-1)) ? '0 : (w_gidx + IDW'(1));

  adder_share_arb_adder u_adder (
    .i_a   (r_op_a),
    .i_b   (r_op_b),
    .o_s   (w_add_s),
    .o_ovf (w_add_ovf)
  );

`ifdef ADDER_SAT_EN
  // On overflow both operands share a sign; that sign picks the saturation rail.
  assign w_result = w_add_ovf ? (r_op_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                              : w_add_s;
`else
  assign w_result = w_add_s;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. RESP always returns to IDLE first, so a new grant
  // cannot be issued in the same cycle that the response retires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = EXEC;
      EXEC:                    w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, round-robin pointer and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_id         <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_sum   <= '0;
      r_resp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_id     <= w_gidx;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        EXEC: begin
          r_resp_sum   <= w_result;
          r_resp_ovf   <= w_add_ovf;
          r_resp_id    <= r_id;
          r_resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_sum   = r_resp_sum;
  assign resp_ovf   = r_resp_ovf;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for adder_share_arb: a two-requester and a three-requester
// instance share clock and reset. Stimulus pushes expected grants and
// responses into queues; per-instance monitors pop and compare on handshakes.
module tb_adder_share_arb;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sum;
    logic        ovf;
  } resp_t;

`ifdef ADDER_SAT_EN
  localparam logic [31:0] EXP_POS_OV = 32'h7FFF_FFFF;
  localparam logic [31:0] EXP_NEG_OV = 32'h8000_0000;
`else
  localparam logic [31:0] EXP_POS_OV = 32'h8000_0000;
  localparam logic [31:0] EXP_NEG_OV = 32'h7FFF_FFFF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  rv2 = '0;
  logic [1:0]  rr2;
  logic [63:0] a2 = '0;
  logic [63:0] b2 = '0;
  logic        vld2;
  logic [1:0]  id2;
  logic        rdy2 = 1'b1;
  logic [31:0] sum2;
  logic        ovf2;
  logic        busy2;

  logic [2:0]  rv3 = '0;
  logic [2:0]  rr3;
  logic [95:0] a3 = '0;
  logic [95:0] b3 = '0;
  logic        vld3;
  logic [1:0]  id3;
  logic        rdy3 = 1'b1;
  logic [31:0] sum3;
  logic        ovf3;
  logic        busy3;

  int n_pass  = 0;
  int n_total = 0;

  resp_t q2[$];
  resp_t q3[$];
  int    g2[$];
  int    g3[$];

  always #5 clk = ~clk;

  adder_share_arb #(.NREQ(2), .IDW(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rr2), .req_a(a2), .req_b(b2),
    .resp_valid(vld2), .resp_id(id2), .resp_ready(rdy2), .resp_sum(sum2),
    .resp_ovf(ovf2), .busy(busy2)
  );

  adder_share_arb #(.NREQ(3), .IDW(2)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .req_a(a3), .req_b(b3),
    .resp_valid(vld3), .resp_id(id3), .resp_ready(rdy3), .resp_sum(sum3),
    .resp_ovf(ovf3), .busy(busy3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic resp_t mk(input logic [1:0] id, input logic [31:0] s, input logic o);
    resp_t r;
    r.id = id; r.sum = s; r.ovf = o;
    return r;
  endfunction

  // Monitor for the NREQ=2 instance.
  always @(negedge clk) begin
    if (!rst) begin
      chk("dut2_ready_onehot", 64'($countones(rr2) <= 1), 64'd1);
      if (|(rr2 & rv2)) begin
        if (g2.size() == 0) chk("dut2_unexpected_grant", 64'(rr2), 64'd0);
        else chk("dut2_grant", 64'(rr2), 64'(1 << g2.pop_front()));
      end
      if (vld2 && rdy2) begin
        if (q2.size() == 0) chk("dut2_unexpected_resp", {id2, sum2, ovf2}, 64'd0);
        else chk("dut2_resp", 64'({id2, sum2, ovf2}), 64'(q2.pop_front()));
      end
    end
  end

  // Monitor for the NREQ=3 instance.
  always @(negedge clk) begin
    if (!rst) begin
      chk("dut3_ready_onehot", 64'($countones(rr3) <= 1), 64'd1);
      if (|(rr3 & rv3)) begin
        if (g3.size() == 0) chk("dut3_unexpected_grant", 64'(rr3), 64'd0);
        else chk("dut3_grant", 64'(rr3), 64'(1 << g3.pop_front()));
      end
      if (vld3 && rdy3) begin
        if (q3.size() == 0) chk("dut3_unexpected_resp", {id3, sum3, ovf3}, 64'd0);
        else chk("dut3_resp", 64'({id3, sum3, ovf3}), 64'(q3.pop_front()));
      end
    end
  end

  // Raise one request on dut2, wait (bounded) for its grant, drop it after the accept edge.
  task automatic req2(input int id, input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    a2[32*id +: 32] = a;
    b2[32*id +: 32] = b;
    rv2[id] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rr2[id]) begin ok = 1; break; end
    end
    if (!ok) chk("req2_grant_timeout", 64'd0, 64'd1);
    tick();
    rv2[id] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (q2.size() == 0 && q3.size() == 0 && g2.size() == 0 && g3.size() == 0) break;
    end
    chk("drain_q2", 64'(q2.size() + g2.size()), 64'd0);
    chk("drain_q3", 64'(q3.size() + g3.size()), 64'd0);
    tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    // Reset values.
    rv2 = 2'b11;
    #2;
    chk("rst_req_ready", 64'(rr2), 64'd0);
    chk("rst_resp_valid", 64'(vld2), 64'd0);
    chk("rst_busy", 64'(busy2), 64'd0);
    chk("rst_resp_sum", 64'(sum2), 64'd0);
    rv2 = 2'b00;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single request with timing.
    rdy2 = 1'b1;
    g2.push_back(0);
    q2.push_back(mk(2'd0, 32'd12, 1'b0));
    req2(0, 32'd5, 32'd7);
    chk("t1_busy_exec", 64'(busy2), 64'd1);
    chk("t1_valid_exec", 64'(vld2), 64'd0);
    tick();
    chk("t1_valid_resp", 64'(vld2), 64'd1);
    chk("t1_busy_resp", 64'(busy2), 64'd1);
    tick();
    chk("t1_busy_done", 64'(busy2), 64'd0);
    chk("t1_valid_done", 64'(vld2), 64'd0);
    drain();

    // Alternating grants from reset.
    rst = 1'b1; tick(); rst = 1'b0;
    a2 = {32'd10, 32'd1};
    b2 = {32'd20, 32'd2};
    for (int k = 0; k < 4; k++) begin
      g2.push_back(k % 2);
      q2.push_back(mk(2'(k % 2), (k % 2) ? 32'd30 : 32'd3, 1'b0));
    end
    rv2 = 2'b11;
    n = 0; ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (|(rr2 & rv2)) begin
        n++;
        if (n == 4) begin ok = 1; tick(); rv2 = 2'b00; break; end
      end
    end
    if (!ok) chk("t2_accept_timeout", 64'(n), 64'd4);
    drain();

    // Arithmetic and overflow vectors.
    g2.push_back(0); q2.push_back(mk(2'd0, EXP_POS_OV, 1'b1));
    req2(0, 32'h7FFF_FFFF, 32'h0000_0001);
    g2.push_back(0); q2.push_back(mk(2'd0, EXP_NEG_OV, 1'b1));
    req2(0, 32'h8000_0000, 32'hFFFF_FFFF);
    g2.push_back(0); q2.push_back(mk(2'd0, 32'hFFFF_FFFF, 1'b0));
    req2(0, 32'h8000_0000, 32'h7FFF_FFFF);
    g2.push_back(0); q2.push_back(mk(2'd0, 32'h0000_0000, 1'b0));
    req2(0, 32'hFFFF_FFFF, 32'h0000_0001);
    g2.push_back(0); q2.push_back(mk(2'd0, 32'hFFFF_FFFE, 1'b0));
    req2(0, 32'hFFFF_FFFB, 32'h0000_0003);
    drain();

    // Backpressure with a pending req1.
    rdy2 = 1'b0;
    g2.push_back(0); q2.push_back(mk(2'd0, 32'd300, 1'b0));
    g2.push_back(1); q2.push_back(mk(2'd1, 32'd7, 1'b0));
    a2 = {32'd3, 32'd100};
    b2 = {32'd4, 32'd200};
    rv2 = 2'b01;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rr2[0]) begin ok = 1; break; end
    end
    if (!ok) chk("t4_grant_timeout", 64'd0, 64'd1);
    tick();
    rv2 = 2'b10;
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", 64'(vld2), 64'd1);
      chk("t4_hold_sum", 64'(sum2), 64'd300);
      chk("t4_hold_id", 64'(id2), 64'd0);
      chk("t4_hold_ready", 64'(rr2), 64'd0);
      tick();
    end
    rdy2 = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 64'(rr2), 64'd0);
    chk("t4_release_valid", 64'(vld2), 64'd1);
    tick();
    @(negedge clk);
    chk("t4_req1_granted", 64'(rr2), 64'd2);
    tick();
    rv2 = 2'b00;
    drain();

    // Reset mid-EXEC: move rr_ptr to 1, then reset and check req0 wins.
    g2.push_back(0);
    req2(0, 32'd50, 32'd50);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(vld2), 64'd0);
    chk("t5_rst_busy", 64'(busy2), 64'd0);
    chk("t5_rst_sum", 64'(sum2), 64'd0);
    chk("t5_rst_id", 64'(id2), 64'd0);
    chk("t5_rst_ovf", 64'(ovf2), 64'd0);
    a2 = {32'd1, 32'd9};
    b2 = {32'd1, 32'd9};
    rv2 = 2'b11;
    @(negedge clk);
    chk("t5_rst_ready", 64'(rr2), 64'd0);
    tick();
    g2.push_back(0); q2.push_back(mk(2'd0, 32'd18, 1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ptr_reset_grant", 64'(rr2), 64'd1);
    tick();
    rv2 = 2'b00;
    drain();

    // NREQ=3: lone req2, then req0+req2 with wrap.
    rdy3 = 1'b1;
    g3.push_back(2); q3.push_back(mk(2'd2, 32'd5, 1'b0));
    g3.push_back(0); q3.push_back(mk(2'd0, 32'd7, 1'b0));
    g3.push_back(2); q3.push_back(mk(2'd2, 32'd8, 1'b0));
    a3[64 +: 32] = 32'd2;
    b3[64 +: 32] = 32'd3;
    rv3 = 3'b100;
    n = 0; ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (|(rr3 & rv3)) begin
        n++;
        if (n == 1) begin
          tick();
          a3[64 +: 32] = 32'd4; b3[64 +: 32] = 32'd4;
          a3[0 +: 32]  = 32'd6; b3[0 +: 32]  = 32'd1;
          rv3 = 3'b101;
        end else if (n == 2) begin
          tick();
          rv3 = 3'b100;
        end else begin
          ok = 1;
          tick();
          rv3 = 3'b000;
          break;
        end
      end
    end
    if (!ok) chk("t6_accept_timeout", 64'(n), 64'd3);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
